// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared read-mode encoding and default thresholds for the FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    typedef enum logic {
        RD_MODE_STD  = 1'b0,
        RD_MODE_FWFT = 1'b1
    } rd_mode_e;

    localparam int AE_THRESH_DEFAULT = 4;
    localparam int AF_MARGIN_DEFAULT = 4;

    function automatic int af_thresh_default(input int ptr_size);
        return (1 << ptr_size) - AF_MARGIN_DEFAULT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_ram.sv
// ============================================================================
// sync_fifo_ram : simple dual-port RAM, one write port, one registered read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is cleared; the array keeps stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sync_fifo_buffer.sv
// ============================================================================
// sync_fifo_buffer : synchronous FIFO with standard or FWFT read, status flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_buffer
    import fifo_pkg::*;
#(
    parameter int fifo_data_size      = 8,
    parameter int fifo_ptr_size       = 8,
    parameter int fwft                = 0,
    parameter int almost_full_thresh  = af_thresh_default(fifo_ptr_size),
    parameter int almost_empty_thresh = AE_THRESH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [fifo_data_size-1:0] wr_din,
    input  logic                      rd_en,
    output logic [fifo_data_size-1:0] rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      almost_full,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [fifo_ptr_size:0]    fill_level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = fifo_ptr_size;
    localparam int DW = fifo_data_size;
    localparam bit IS_FWFT = (fwft == int'(RD_MODE_FWFT));
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_LVL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   AF_LVL    = (AW+1)'(almost_full_thresh);
    localparam logic [AW:0]   AE_LVL    = (AW+1)'(almost_empty_thresh);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d, mem_cnt_q, mem_cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic          full_q, afull_q, empty_q, aempty_q, ovf_q, udf_q;
    logic          wr_acc, ram_rd, pop, rd_reject;

    always_comb begin
        wr_acc = wr_en && !full_q;
        // FWFT: prefetch whenever the output register is free or being popped.
        if (IS_FWFT) begin
            ram_rd     = (mem_cnt_q != '0) && (!rd_valid_q || rd_en);
            pop        = rd_en && rd_valid_q;
            rd_reject  = rd_en && !rd_valid_q;
            rd_valid_d = ram_rd || (rd_valid_q && !pop);
        end else begin
            ram_rd     = rd_en && !empty_q;
            pop        = ram_rd;
            rd_reject  = rd_en && empty_q;
            rd_valid_d = ram_rd;
        end

        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = ram_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        fill_d = fill_q;
        if (wr_acc && !pop) begin
            fill_d = fill_q + CNT_ONE;
        end else if (!wr_acc && pop) begin
            fill_d = fill_q - CNT_ONE;
        end

        mem_cnt_d = mem_cnt_q;
        if (wr_acc && !ram_rd) begin
            mem_cnt_d = mem_cnt_q + CNT_ONE;
        end else if (!wr_acc && ram_rd) begin
            mem_cnt_d = mem_cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            mem_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            empty_q    <= 1'b1;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            mem_cnt_q  <= mem_cnt_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= (fill_d == DEPTH_LVL);
            afull_q    <= (fill_d >= AF_LVL);
            empty_q    <= (fill_d == '0);
            aempty_q   <= (fill_d <= AE_LVL);
            ovf_q      <= wr_en && full_q;
            udf_q      <= rd_reject;
        end
    end

    sync_fifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_din),
        .rd_en_i   (ram_rd),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign fill_level   = fill_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

`default_nettype wire

// File: doc/sync_fifo_buffer.md
SYNC_FIFO_BUFFER -- requirements
Module: sync_fifo_buffer

Interface
REQ-001 Parameter: fifo_data_size, default 8, data word width in bits.
REQ-002 Parameter: fifo_ptr_size, default 8, address width; depth = 2**fifo_ptr_size words.
REQ-003 Parameter: fwft, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 Parameter: almost_full_thresh, default (2**fifo_ptr_size)-4, almost_full asserts when fill_level >= this value.
REQ-005 Parameter: almost_empty_thresh, default 4, almost_empty asserts when fill_level <= this value.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 Port: rst_n  input  1  asynchronous active-low reset.
REQ-009 Port: wr_en  input  1  write request.
REQ-010 Port: wr_din  input  fifo_data_size  write data.
REQ-011 Port: rd_en  input  1  read request (standard mode) or pop (fwft mode).
REQ-012 Port: rd_data  output  fifo_data_size  read data, registered.
REQ-013 Port: rd_valid  output  1  rd_data holds a valid word.
REQ-014 Port: full, almost_full, empty, almost_empty  output  1 each  registered status flags.
REQ-015 Port: fill_level  output  fifo_ptr_size+1  words held, 0..depth.
REQ-016 Port: overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-017 Write accepted iff wr_en=1 and full=0; word stored at wr_ptr; wr_ptr increments modulo depth.
REQ-018 wr_en=1 while full=1 SHALL be dropped, memory and pointers unchanged, overflow pulses next cycle, even if rd_en=1 in the same cycle.
REQ-019 Standard mode: read accepted iff rd_en=1 and empty=0; rd_data = word at rd_ptr one cycle later, rd_valid=1 for exactly that cycle; rd_data holds its value until the next accepted read.
REQ-020 fwft mode: when the output register is empty and memory non-empty, the head word is prefetched into rd_data; rd_valid=1 while rd_data holds an unpopped word; rd_en=1 with rd_valid=1 pops it, and the next word (if any) appears the following cycle.
REQ-021 rd_en=1 while nothing is readable (empty=1 in standard mode, rd_valid=0 in fwft mode) SHALL be ignored, and underflow pulses next cycle.
REQ-022 Simultaneous accepted read and write: both occur; fill_level unchanged.
REQ-023 Simultaneous rd_en and wr_en on an empty FIFO: write accepted, read rejected with underflow; no write-to-read bypass.
REQ-024 fill_level counts words in memory plus, in fwft mode, an unpopped word in the output register; full = (fill_level == depth); empty = (fill_level == 0).
REQ-025 Flags and fill_level SHALL update in the cycle after the causing event; in standard mode, a write to an empty FIFO deasserts empty after 1 cycle; in fwft mode, rd_valid asserts 2 cycles after that write.
REQ-026 Pointers SHALL wrap from depth-1 to 0 with no data loss or flag glitch.

Reset
REQ-027 While rst_n=0: pointers, fill_level and rd_data = 0; rd_valid, full, almost_full, overflow and underflow = 0; empty and almost_empty = 1.
REQ-028 Reset asserted mid-operation SHALL discard all contents immediately; memory array contents are not reset.
REQ-029 Reset deassertion is synchronised externally; the block accepts wr_en on the first clk edge after release.

Structure
REQ-030 Default threshold values and the read-mode encoding SHALL live in shared package fifo_pkg.
REQ-031 Storage SHALL be sub-module sync_fifo_ram: simple dual-port RAM with one write port and one registered read port on clk, inferable as block RAM.
REQ-032 Pointer, count and flag logic and the fwft output register SHALL be in sync_fifo_buffer.

Verification
REQ-033 Standard mode, depth 16: write 0x01..0x10 -> full=1 after 16th write, fill_level=16; 17th write -> overflow pulse, contents unchanged.
REQ-034 Standard mode: read 16 words -> 0x01..0x10 in order, one cycle after each rd_en; empty=1 after last; extra rd_en -> underflow pulse.
REQ-035 fwft mode: single write 0xA5 to empty FIFO -> rd_valid=1 with rd_data=0xA5 two cycles later; rd_en -> rd_valid=0 next cycle, fill_level=0.
REQ-036 Continuous simultaneous rd_en/wr_en at fill_level=8 for 40 cycles -> fill_level stays 8, pointers wrap, output order is exact FIFO order.
REQ-037 Thresholds 12/4: fill 0->13 then drain to 3 -> almost_full rises at fill 12, falls at 11; almost_empty falls at 5, rises at 4.
REQ-038 rst_n pulsed low at fill_level=9 -> empty=1, fill_level=0 and rd_valid=0 immediately; the next write reads back correctly.
